// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg -- shared constants, types and helpers for the ula_matricial slice.
//   N, DW, ACCW : matrix dimension, element width, product accumulator width
//   OP_*        : operation codes (110/111 are invalid)
//   state_t     : FSM encoding (IDLE, CALC, FIM)
//   reduz_dw    : reduces a full-precision result to DW bits. With the macro
//                 ULA_SATURACAO_EN defined it clamps to [-128,127], otherwise
//                 it keeps the low DW bits (wrap).
//   fora_faixa  : true when a full-precision result does not fit in DW bits
// ---------------------------------------------------------------------------
package ula_pkg;

   localparam int N    = 5;
   localparam int DW   = 8;
   localparam int ACCW = 20;
   localparam int NN   = N * N;
   localparam int IW   = 5;

   localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
   localparam logic [2:0]    LAST_K   = 3'(N - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_ESC = 3'b011;
   localparam logic [2:0] OP_TRP = 3'b100;
   localparam logic [2:0] OP_NEG = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIM  = 2'd2
   } state_t;

   localparam logic signed [ACCW-1:0] MAX_V = ACCW'(127);
   localparam logic signed [ACCW-1:0] MIN_V = ACCW'(-128);

   function automatic logic fora_faixa(input logic signed [ACCW-1:0] v);
      return (v > MAX_V) || (v < MIN_V);
   endfunction

   function automatic logic [DW-1:0] reduz_dw(input logic signed [ACCW-1:0] v);
`ifdef ULA_SATURACAO_EN
      if (v > MAX_V)
         return 8'h7F;
      else if (v < MIN_V)
         return 8'h80;
      else
         return v[DW-1:0];
`else
      return v[DW-1:0];
`endif
   endfunction

endpackage

// File: rtl/ula_matricial_if.sv
// ---------------------------------------------------------------------------
// ula_matricial_if -- operand-write, command/status and result-read signals
// between the HPS input manager (master) and the matrix ALU (slave).
//   wr_en/wr_idx/wr_a/wr_b : load A[wr_idx] and B[wr_idx]
//   opcode/start           : launch an operation
//   busy/done/ovf/err      : status
//   rd_idx/rd_data         : read C[rd_idx], one cycle latency
// ---------------------------------------------------------------------------
interface ula_matricial_if;
   import ula_pkg::*;

   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [DW-1:0] wr_a;
   logic [DW-1:0] wr_b;
   logic [2:0]    opcode;
   logic          start;
   logic          busy;
   logic          done;
   logic          ovf;
   logic          err;
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_data;

   modport master (
      output wr_en, wr_idx, wr_a, wr_b, opcode, start, rd_idx,
      input  busy, done, ovf, err, rd_data
   );

   modport slave (
      input  wr_en, wr_idx, wr_a, wr_b, opcode, start, rd_idx,
      output busy, done, ovf, err, rd_data
   );

endinterface

// File: rtl/ula_matricial_mac_elemento.sv
// ---------------------------------------------------------------------------
// mac_elemento -- signed DW x DW multiply-accumulate, ACCW wide.
//   clk, reset : clock, synchronous active-low reset
//   clr        : this product starts a new sum (previous total ignored)
//   en         : commit acc_sum into the accumulator
//   a, b       : signed operands
//   acc_sum    : combinational (clr ? 0 : acc) + a*b, i.e. the running total
//                including the current product, usable in the same cycle
// ---------------------------------------------------------------------------
module mac_elemento
   import ula_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [DW-1:0]   a,
   input  logic signed [DW-1:0]   b,
   output logic signed [ACCW-1:0] acc_sum
);

   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] acc_reg;

   assign prod    = a * b;
   assign acc_sum = (clr ? '0 : acc_reg) + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

   always_ff @(posedge clk) begin
      if (!reset)
         acc_reg <= '0;
      else if (en)
         acc_reg <= acc_sum;
   end

endmodule

// File: rtl/ula_matricial.sv
// ---------------------------------------------------------------------------
// ula_matricial -- 5x5 signed 8-bit matrix ALU.
//   clk   : system clock
//   reset : synchronous, active-low; aborts any operation (C keeps whatever
//           was already written), matrix storage is not cleared
//   bus   : ula_matricial_if.slave (operand writes, opcode/start, status,
//           result reads)
// Operations run sequentially, one C element per cycle (MUL: five cycles
// per element). Build option: define ULA_SATURACAO_EN to clamp out-of-range
// results instead of wrapping them; ovf is raised either way.
// ---------------------------------------------------------------------------
module ula_matricial
   import ula_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ula_matricial_if.slave bus
);

   logic [DW-1:0] mem_a [0:NN-1];
   logic [DW-1:0] mem_b [0:NN-1];
   logic [DW-1:0] mem_c [0:NN-1];

   state_t          state_reg, state_next;
   logic [2:0]      op_reg, op_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [2:0]      row_reg, row_next;
   logic [2:0]      col_reg, col_next;
   logic [2:0]      k_reg, k_next;
   logic            ovf_reg, ovf_next;
   logic            err_reg, err_next;
   logic [DW-1:0]   rd_data_reg;
   logic            c_we;
   logic            last_el;
   logic            mac_clr, mac_en;
   logic [IW-1:0]   a_addr, b_addr;
   logic signed [DW-1:0]   a_val, b_val;
   logic signed [ACCW-1:0] a_ext, b_ext, res, mac_sum;

   // Operand addresses: MUL walks row i of A and column j of B with k,
   // ESC always uses B[0], TRP reads A at the mirrored position.
   always_comb begin
      a_addr = idx_reg;
      b_addr = idx_reg;
      case (op_reg)
         OP_MUL: begin
            a_addr = IW'(row_reg) * IW'(N) + IW'(k_reg);
            b_addr = IW'(k_reg) * IW'(N) + IW'(col_reg);
         end
         OP_ESC: b_addr = '0;
         OP_TRP: a_addr = IW'(col_reg) * IW'(N) + IW'(row_reg);
         default: ;
      endcase
   end

   assign a_val = $signed(mem_a[a_addr]);
   assign b_val = $signed(mem_b[b_addr]);
   assign a_ext = {{(ACCW-DW){a_val[DW-1]}}, a_val};
   assign b_ext = {{(ACCW-DW){b_val[DW-1]}}, b_val};

   // ESC uses the MAC with clr held, so acc_sum is just the product.
   assign mac_clr = (op_reg != OP_MUL) || (k_reg == '0);
   assign mac_en  = (state_reg == CALC);

   mac_elemento u_mac (
      .clk     (clk),
      .reset   (reset),
      .clr     (mac_clr),
      .en      (mac_en),
      .a       (a_val),
      .b       (b_val),
      .acc_sum (mac_sum)
   );

   always_comb begin
      res = mac_sum;
      case (op_reg)
         OP_ADD:  res = a_ext + b_ext;
         OP_SUB:  res = a_ext - b_ext;
         OP_TRP:  res = a_ext;
         OP_NEG:  res = -a_ext;
         default: res = mac_sum;
      endcase
   end

   // Element-wise ops finish an element every cycle; MUL only on k == N-1.
   assign last_el = (op_reg != OP_MUL) || (k_reg == LAST_K);

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      idx_next   = idx_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      k_next     = k_reg;
      ovf_next   = ovf_reg;
      err_next   = err_reg;
      c_we       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               op_next  = bus.opcode;
               ovf_next = 1'b0;
               err_next = 1'b0;
               idx_next = '0;
               row_next = '0;
               col_next = '0;
               k_next   = '0;
               if (bus.opcode > OP_NEG) begin
                  err_next   = 1'b1;
                  state_next = FIM;
               end else begin
                  state_next = CALC;
               end
            end
         end
         CALC: begin
            if (last_el) begin
               c_we   = 1'b1;
               k_next = '0;
               if (fora_faixa(res))
                  ovf_next = 1'b1;
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  row_next   = '0;
                  col_next   = '0;
                  state_next = FIM;
               end else begin
                  idx_next = idx_reg + 1'b1;
                  if (col_reg == LAST_K) begin
                     col_next = '0;
                     row_next = row_reg + 1'b1;
                  end else begin
                     col_next = col_reg + 1'b1;
                  end
               end
            end else begin
               k_next = k_reg + 1'b1;
            end
         end
         FIM:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         op_reg    <= OP_ADD;
         idx_reg   <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
         k_reg     <= '0;
         ovf_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         idx_reg   <= idx_next;
         row_reg   <= row_next;
         col_reg   <= col_next;
         k_reg     <= k_next;
         ovf_reg   <= ovf_next;
         err_reg   <= err_next;
      end
   end

   // Operands are frozen while computing; a write and start in the same
   // IDLE cycle lands before the first CALC read.
   always_ff @(posedge clk) begin
      if (bus.wr_en && (state_reg != CALC) && (bus.wr_idx <= LAST_IDX)) begin
         mem_a[bus.wr_idx] <= bus.wr_a;
         mem_b[bus.wr_idx] <= bus.wr_b;
      end
      if (reset && c_we)
         mem_c[idx_reg] <= reduz_dw(res);
   end

   always_ff @(posedge clk) begin
      if (!reset)
         rd_data_reg <= '0;
      else if (bus.rd_idx <= LAST_IDX)
         rd_data_reg <= mem_c[bus.rd_idx];
      else
         rd_data_reg <= '0;
   end

   assign bus.busy    = (state_reg == CALC);
   assign bus.done    = (state_reg == FIM);
   assign bus.ovf     = ovf_reg;
   assign bus.err     = err_reg;
   assign bus.rd_data = rd_data_reg;

endmodule
